multiclickreg: RTL and testbench
================================

MULTICLICKREG -- requirements
Module: multiclickreg

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning strobe and delta channel count (1..16).
REQ-002 SHALL have parameter TIMER_W, default 36, meaning timestamp width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning record FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter LOST_W, default 16, meaning lost-record counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port strobe_channels, input, N_CH, pulse inputs, active high.
REQ-008 SHALL have port delta_channels, input, N_CH, level inputs; any change is an event.
REQ-009 SHALL have port strobe_mask, input, N_CH, 1 = channel enabled.
REQ-010 SHALL have port delta_mask, input, N_CH, 1 = channel enabled.
REQ-011 SHALL have port clear, input, 1, synchronous timer clear.
REQ-012 SHALL have port operate, input, 1, enables wraparound records.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts record.
REQ-014 SHALL have port out_valid, output, 1, record available.
REQ-015 SHALL have port out_data, output, TIMER_W+N_CH+2, record: [TIMER_W-1:0] timestamp, [TIMER_W+N_CH-1:TIMER_W] channels, [TIMER_W+N_CH] type (1=delta, 0=strobe/wrap), MSB wrap flag.
REQ-016 SHALL have port fifo_level, output, clog2(DEPTH)+1, stored record count.
REQ-017 SHALL have port lost_count, output, LOST_W, saturating count of dropped records.

Function
REQ-018 Timer SHALL increment by 1 every cycle, wrap modulo 2^TIMER_W, and load 0 on the edge where clear=1.
REQ-019 Timestamp SHALL equal the timer value sampled at the edge the event is captured (pre-increment).
REQ-020 Delta event SHALL be (delta_channels & delta_mask) != old_delta; on capture old_delta SHALL load the masked value and channels field SHALL carry it.
REQ-021 Strobe event SHALL be |(strobe_channels & strobe_mask); channels field SHALL carry the masked strobe vector.
REQ-022 Wrap event SHALL be timer==0 with operate=1; wrap-only record SHALL have channels=0, type=0.
REQ-023 Wrap flag SHALL be 1 in every record whose timestamp is 0, else 0.
REQ-024 Capture priority per cycle SHALL be: delta > pending strobe > new strobe > wrap-only.
REQ-025 Delta and new strobe in the same cycle: delta captured; strobe record (own timestamp) held in a one-entry pending register and captured next cycle.
REQ-026 Any event not captured and not pended (pending register occupied, or wrap-only losing priority to another record) SHALL increment lost_count by 1.
REQ-027 Captured record SHALL enter a capture register on edge k and be written to the FIFO on edge k+1.
REQ-028 FIFO SHALL be first-word fall-through: empty FIFO written on edge k+1 gives out_valid=1 with that record after edge k+1.
REQ-029 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Write to a full FIFO SHALL be accepted if a pop occurs on the same edge, otherwise dropped and lost_count incremented.
REQ-031 Simultaneous push and pop SHALL leave fifo_level unchanged; records SHALL leave in capture order.
REQ-032 lost_count SHALL saturate at 2^LOST_W-1; two loss sources in one cycle SHALL add 2 (saturating).
REQ-033 Mask changes SHALL take effect the same cycle; unmasking a delta bit whose level differs from old_delta SHALL produce a delta event.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear timer, old_delta, pending register, capture register, FIFO pointers, lost_count; out_valid=0, fifo_level=0, out_data=0.
REQ-035 Reset mid-operation SHALL discard all stored and pending records; first record after release SHALL have timestamp relative to timer restarting at 0.
REQ-036 Events present during the first edge after rst_n rises SHALL be captured normally.

Verification
REQ-037 Strobe 4'b0010 with timer=5, masks all 1, out_ready=1 -> after 2 edges out_valid=1, timestamp 5, channels 0010, type 0, wrap 0.
REQ-038 Delta 0000->0101 and strobe 1000 same cycle at timer=9 -> delta record ts 9 type 1 then strobe record ts 9 channels 1000 type 0; lost_count=0.
REQ-039 Strobes on 3 consecutive cycles while delta toggles each cycle -> second and third strobes hit occupied pending register; lost_count per REQ-026, no reordering.
REQ-040 out_ready=0, DEPTH+3 strobe events -> fifo_level=DEPTH, lost_count=3, first DEPTH records drained in order.
REQ-041 TIMER_W=4, operate=1, no inputs -> wrap-only record ts 0, wrap 1 every 16 cycles; operate=0 -> none.
REQ-042 rst_n pulsed low with fifo_level=5, pending set -> out_valid=0, fifo_level=0, lost_count=0 immediately, no stale records after release.

Source files
------------

// File: rtl/multiclickreg.sv
// Multi-channel event timestamper: strobe/delta/wrap events are stamped with a free-running
// timer, staged through a capture register and buffered in a first-word-fall-through FIFO.
module multiclickreg #(
  parameter int N_CH    = 4,
  parameter int TIMER_W = 36,
  parameter int DEPTH   = 16,
  parameter int LOST_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             strobe_channels,
  input  logic [N_CH-1:0]             delta_channels,
  input  logic [N_CH-1:0]             strobe_mask,
  input  logic [N_CH-1:0]             delta_mask,
  input  logic                        clear,
  input  logic                        operate,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [TIMER_W+N_CH+1:0]     out_data,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [LOST_W-1:0]           lost_count
);

  localparam int REC_W = TIMER_W + N_CH + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int SW    = LOST_W + 2;

  function automatic logic [REC_W-1:0] make_rec(input logic [TIMER_W-1:0] ts,
                                                 input logic [N_CH-1:0]    ch,
                                                 input logic               is_delta);
    make_rec = {(ts == '0), is_delta, ch, ts};
  endfunction

  function automatic logic [LOST_W-1:0] sat_add(input logic [LOST_W-1:0] a,
                                                input logic [1:0]        inc);
    logic [SW-1:0] sum;
    sum = SW'(a) + SW'(inc);
    if (|sum[SW-1:LOST_W]) sat_add = '1;
    else                   sat_add = sum[LOST_W-1:0];
  endfunction

  logic [TIMER_W-1:0] r_timer;
  logic [N_CH-1:0]    r_old_delta;
  logic               r_pend_vld;
  logic [REC_W-1:0]   r_pend_rec;
  logic               r_vld_p1;
  logic [REC_W-1:0]   r_rec_p1;
  logic [REC_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [LOST_W-1:0]  r_lost;

  logic [N_CH-1:0]    w_delta_m;
  logic [N_CH-1:0]    w_strb_m;
  logic               w_delta_ev;
  logic               w_strb_ev;
  logic               w_wrap_ev;
  logic               w_cap_vld;
  logic [REC_W-1:0]   w_cap_rec;
  logic               w_pend_set;
  logic               w_pend_take;
  logic [REC_W-1:0]   w_pend_rec;
  logic [1:0]         w_ev_lost;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [1:0]         w_loss_inc;

  assign w_delta_m  = delta_channels & delta_mask;
  assign w_strb_m   = strobe_channels & strobe_mask;
  assign w_delta_ev = (w_delta_m != r_old_delta);
  assign w_strb_ev  = |w_strb_m;
  assign w_wrap_ev  = (r_timer == '0) && operate;
  assign w_pend_rec = make_rec(r_timer, w_strb_m, 1'b0);

  // Stage p0: arbitrate delta > pending strobe > new strobe > wrap-only.
  // A pending slot drained this cycle may be refilled by a new strobe in the same cycle.
  always_comb begin
    w_cap_vld   = 1'b0;
    w_cap_rec   = '0;
    w_pend_set  = 1'b0;
    w_pend_take = 1'b0;
    w_ev_lost   = 2'd0;
    if (w_delta_ev) begin
      w_cap_vld = 1'b1;
      w_cap_rec = make_rec(r_timer, w_delta_m, 1'b1);
      if (w_strb_ev) begin
        if (r_pend_vld) w_ev_lost = w_ev_lost + 2'd1;
        else            w_pend_set = 1'b1;
      end
      if (w_wrap_ev) w_ev_lost = w_ev_lost + 2'd1;
    end else if (r_pend_vld) begin
      w_cap_vld   = 1'b1;
      w_cap_rec   = r_pend_rec;
      w_pend_take = 1'b1;
      if (w_strb_ev) w_pend_set = 1'b1;
      if (w_wrap_ev) w_ev_lost = w_ev_lost + 2'd1;
    end else if (w_strb_ev) begin
      w_cap_vld = 1'b1;
      w_cap_rec = make_rec(r_timer, w_strb_m, 1'b0);
      if (w_wrap_ev) w_ev_lost = w_ev_lost + 2'd1;
    end else if (w_wrap_ev) begin
      w_cap_vld = 1'b1;
      w_cap_rec = make_rec(r_timer, '0, 1'b0);
    end
  end

  // Stage p1: capture register drains into the FIFO; a full FIFO still accepts on a pop.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = out_valid && out_ready;
  assign w_push     = r_vld_p1 && (!w_full || w_pop);
  assign w_drop     = r_vld_p1 && w_full && !w_pop;
  assign w_loss_inc = w_ev_lost + {1'b0, w_drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_old_delta <= '0;
      r_pend_vld  <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_lost      <= '0;
    end else begin
      r_timer <= clear ? '0 : r_timer + TIMER_W'(1);
      if (w_delta_ev) r_old_delta <= w_delta_m;
      if (w_pend_set)       r_pend_vld <= 1'b1;
      else if (w_pend_take) r_pend_vld <= 1'b0;
      r_vld_p1 <= w_cap_vld;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_lost  <= sat_add(r_lost, w_loss_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (w_pend_set) r_pend_rec <= w_pend_rec;
    if (w_cap_vld)  r_rec_p1   <= w_cap_rec;
    if (w_push)     r_mem[r_wr_ptr] <= r_rec_p1;
  end

  // Stage p2: fall-through read; data forced to zero whenever nothing is stored.
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_count;
  assign lost_count = r_lost;

endmodule

// File: tb/tb_multiclickreg.sv
// Directed bench for multiclickreg with a small configuration (4 channels, 4-bit timer, depth 4).
module tb_multiclickreg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] strobe_channels, delta_channels, strobe_mask, delta_mask;
  logic       clear, operate, out_ready;
  logic       out_valid;
  logic [9:0] out_data;
  logic [2:0] fifo_level;
  logic [3:0] lost_count;

  int total = 0;
  int bad   = 0;

  multiclickreg #(.N_CH(4), .TIMER_W(4), .DEPTH(4), .LOST_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .strobe_channels(strobe_channels), .delta_channels(delta_channels),
    .strobe_mask(strobe_mask), .delta_mask(delta_mask),
    .clear(clear), .operate(operate), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .fifo_level(fifo_level), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ts;
    logic [3:0] s;
    logic [3:0] d;
    logic [3:0] sm;
    logic [3:0] dm;
    logic       ev;
    logic [9:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    strobe_channels = '0;
    delta_channels  = '0;
    clear = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // After this the next rising edge sees timer == t.
  task automatic set_timer(input int t);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (t) step();
  endtask

  task automatic pop_chk(input string nm, input logic [9:0] exp);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [9:0] held;
    rst_n = 1'b0;
    strobe_channels = '0; delta_channels = '0;
    strobe_mask = 4'hF; delta_mask = 4'hF;
    clear = 1'b0; operate = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_lost",  lost_count, 0);
    chk("rst_data",  out_data, 0);

    // record = {wrap, type, ch[3:0], ts[3:0]}
    vt[0] = '{4'd5,  4'b0010, 4'b0000, 4'hF,    4'hF,    1'b1, 10'b00_0010_0101};
    vt[1] = '{4'd7,  4'b0000, 4'b0110, 4'hF,    4'hF,    1'b1, 10'b01_0110_0111};
    vt[2] = '{4'd3,  4'b1010, 4'b0000, 4'b0010, 4'hF,    1'b1, 10'b00_0010_0011};
    vt[3] = '{4'd3,  4'b1000, 4'b0000, 4'b0111, 4'hF,    1'b0, 10'b00_0000_0000};
    vt[4] = '{4'd0,  4'b0001, 4'b0000, 4'hF,    4'hF,    1'b1, 10'b10_0001_0000};
    vt[5] = '{4'd12, 4'b0000, 4'b1111, 4'hF,    4'b1001, 1'b1, 10'b01_1001_1100};
    vt[6] = '{4'd15, 4'b0000, 4'b0100, 4'hF,    4'b0000, 1'b0, 10'b00_0000_0000};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      strobe_mask = vt[i].sm;
      delta_mask  = vt[i].dm;
      set_timer(int'(vt[i].ts));
      strobe_channels = vt[i].s;
      delta_channels  = vt[i].d;
      step();
      strobe_channels = '0;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].ev);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
    end
    strobe_mask = 4'hF; delta_mask = 4'hF;

    // Delta and strobe together: delta first, strobe held one cycle with its own stamp.
    do_reset();
    set_timer(9);
    delta_channels = 4'b0101; strobe_channels = 4'b1000;
    step();
    strobe_channels = '0;
    step();
    chk("dual_first_data", out_data, 10'b01_0101_1001);
    held = out_data;
    step();
    chk("dual_hold_data", out_data, held);
    chk("dual_level", fifo_level, 2);
    pop_chk("dual_d", 10'b01_0101_1001);
    pop_chk("dual_s", 10'b00_1000_1001);
    chk("dual_lost", lost_count, 0);

    // Strobes on three cycles with delta toggling: pending slot blocks the 2nd and 3rd.
    do_reset();
    set_timer(2);
    delta_channels = 4'b0001; strobe_channels = 4'b0001; step();
    delta_channels = 4'b0000; strobe_channels = 4'b0010; step();
    delta_channels = 4'b0001; strobe_channels = 4'b0100; step();
    strobe_channels = '0;
    step(); step();
    chk("tog_level", fifo_level, 4);
    chk("tog_lost", lost_count, 2);
    pop_chk("tog_d2", 10'b01_0001_0010);
    pop_chk("tog_d3", 10'b01_0000_0011);
    pop_chk("tog_d4", 10'b01_0001_0100);
    pop_chk("tog_s2", 10'b00_0001_0010);
    chk("tog_empty", out_valid, 0);

    // Overfill: depth + 3 strobes with no consumer.
    do_reset();
    set_timer(1);
    strobe_channels = 4'b0001;
    repeat (7) step();
    strobe_channels = '0;
    step();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_lost", lost_count, 3);
    pop_chk("ovf_r1", 10'b00_0001_0001);
    pop_chk("ovf_r2", 10'b00_0001_0010);
    pop_chk("ovf_r3", 10'b00_0001_0011);
    pop_chk("ovf_r4", 10'b00_0001_0100);
    chk("ovf_empty", out_valid, 0);

    // Two event losses in one cycle (blocked strobe + blocked wrap), delta at ts 0 flags wrap.
    do_reset();
    set_timer(15);
    delta_channels = 4'b0001; strobe_channels = 4'b0001; step();
    delta_channels = 4'b0000; strobe_channels = 4'b0010; operate = 1'b1; step();
    operate = 1'b0; strobe_channels = '0;
    step(); step();
    chk("dbl_lost", lost_count, 2);
    chk("dbl_level", fifo_level, 3);
    pop_chk("dbl_d15", 10'b01_0001_1111);
    pop_chk("dbl_d0",  10'b11_0000_0000);
    pop_chk("dbl_s15", 10'b00_0001_1111);

    // Saturation of the lost counter.
    do_reset();
    strobe_channels = 4'b0001;
    repeat (30) step();
    strobe_channels = '0;
    step(); step();
    chk("sat_lost", lost_count, 15);
    chk("sat_level", fifo_level, 4);

    // Unmasking a delta bit that differs from the stored level is an event that cycle.
    do_reset();
    delta_mask = 4'b0000;
    delta_channels = 4'b0100;
    set_timer(6);
    chk("unmask_before", out_valid, 0);
    delta_mask = 4'hF;
    step(); step();
    pop_chk("unmask", 10'b01_0100_0110);

    // Wrap-only records every 16 cycles while operate is set, none otherwise.
    do_reset();
    rst_n = 1'b0; operate = 1'b1; out_ready = 1'b1; #1; rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (out_valid) begin
        n++;
        chk("wrap_data", out_data, 10'b10_0000_0000);
      end
    end
    chk("wrap_count", n, 3);
    operate = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) n++;
    end
    chk("nowrap_count", n, 0);
    out_ready = 1'b0;

    // Reset in the middle of operation with a full FIFO and a pending strobe.
    do_reset();
    strobe_channels = 4'b0001;
    repeat (5) step();
    strobe_channels = 4'b0100; delta_channels = 4'b0010;
    step();
    chk("mid_pre_level", fifo_level, 4);
    chk("mid_pre_lost", lost_count, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_level", fifo_level, 0);
    chk("mid_lost", lost_count, 0);
    chk("mid_data", out_data, 0);
    strobe_channels = 4'b1000; delta_channels = 4'b0000;
    rst_n = 1'b1;
    step();
    strobe_channels = '0;
    out_ready = 1'b1;
    step();
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 10'b10_1000_0000);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) n++;
    end
    chk("post_stale", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
